// File: rtl/lsu_ram_master.sv
// Load/store initiator for a word-wide RAM with a combinational read port.
// Handles lane extraction and extension for loads and read-modify-write for sub-word stores.
module lsu_ram_master #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg, unsigned_reg, err_reg;
    logic [1:0]  size_reg, off_reg;
    logic [15:0] wdata_reg;
    logic [31:0] mem_addr_reg, mem_wdata_reg, rdata_reg;

    logic        accept, req_err;
    logic [31:0] load_lane, load_ext, store_pattern, merged_word;
    logic [3:0]  lane_mask;

    assign req_ready_o = (state_reg == IDLE) && rst;
    assign accept      = req_valid_i && req_ready_o;

    assign req_err = (req_size_i == 2'b11)
                  || ((req_size_i == 2'b01) && req_addr_i[0])
                  || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
                  || ({2'b00, req_addr_i[31:2]} >= 32'(MEM_WORDS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we_i && (req_size_i == 2'b10))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = rsp_ready_i ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Little-endian lane select, then sign/zero extension by access size
    assign load_lane = mem_rdata_i >> {off_reg, 3'b000};

    always_comb begin
        load_ext = load_lane;
        case (size_reg)
            2'b00:   load_ext = {{24{~unsigned_reg & load_lane[7]}}, load_lane[7:0]};
            2'b01:   load_ext = {{16{~unsigned_reg & load_lane[15]}}, load_lane[15:0]};
            default: load_ext = load_lane;
        endcase
    end

    // Replicate store data across the word so each lane can pick its own byte
    assign store_pattern = (size_reg == 2'b00) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_mask[gi] = (size_reg == 2'b00) ? (off_reg == LANE) : (off_reg[1] == LANE[1]);
            assign merged_word[8*gi +: 8] = lane_mask[gi] ? store_pattern[8*gi +: 8]
                                                          : mem_rdata_i[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg        <= 1'b0;
            unsigned_reg  <= 1'b0;
            err_reg       <= 1'b0;
            size_reg      <= 2'b00;
            off_reg       <= 2'b00;
            wdata_reg     <= 16'h0000;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            rdata_reg     <= 32'h0;
        end else if (accept) begin
            we_reg       <= req_we_i;
            unsigned_reg <= req_unsigned_i;
            err_reg      <= req_err;
            size_reg     <= req_size_i;
            off_reg      <= req_addr_i[1:0];
            wdata_reg    <= req_wdata_i[15:0];
            mem_addr_reg <= {req_addr_i[31:2], 2'b00};
            rdata_reg    <= 32'h0;
            // Word stores skip the read, so their write data is ready at accept
            if (req_we_i && (req_size_i == 2'b10) && !req_err)
                mem_wdata_reg <= req_wdata_i;
        end else if (state_reg == RD) begin
            if (we_reg)
                mem_wdata_reg <= merged_word;
            else
                rdata_reg <= load_ext;
        end
    end

    // Write enable decodes straight from state so reset kills it immediately
    assign mem_we_o    = (state_reg == WR);
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_rdata_o = rdata_reg;
    assign rsp_err_o   = err_reg;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Randomized bench for lsu_ram_master: a small RAM, a byte-level reference model,
// directed scenarios for extension, errors, backpressure and reset during a write.
module tb_lsu_ram_master;

    localparam int MEM_WORDS = 4096;
    localparam int SPAN      = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    lsu_ram_master #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM environment: DUT writes plus a backdoor port for preloading
    logic [31:0] ram [0:SPAN-1];
    logic [31:0] ref_mem [0:SPAN-1];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_data = 32'h0;
    int          we_cnt = 0;
    logic [31:0] wa = 32'h0, wd = 32'h0;

    assign mem_rdata_i = (mem_addr_o[31:8] == 24'd0) ? ram[mem_addr_o[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we_o) begin
            we_cnt <= we_cnt + 1;
            wa     <= mem_addr_o;
            wd     <= mem_wdata_o;
            if (mem_addr_o[31:8] == 24'd0)
                ram[mem_addr_o[7:2]] <= mem_wdata_o;
        end else if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 6'(idx); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Expected response computed byte by byte from the access rules
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output logic [31:0] new_word, output int lat);
        int nbytes, off;
        logic [31:0] w, v, mask;
        nbytes = 1 << size;
        off    = int'(addr % 4);
        err    = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                 (size == 2'd2 && addr % 4 != 0) || ((addr / 4) >= 32'(MEM_WORDS));
        rdata    = 32'h0;
        new_word = 32'h0;
        if (err) begin
            lat = 1;
        end else begin
            w = ref_mem[addr[7:2]];
            new_word = w;
            if (!we) begin
                v = w >> (8 * off);
                if (nbytes < 4) begin
                    mask = (32'h1 << (8 * nbytes)) - 32'h1;
                    v = v & mask;
                    if (!uns && v[8*nbytes-1]) v = v | ~mask;
                end
                rdata = v;
                lat = 2;
            end else begin
                for (int k = 0; k < nbytes; k++)
                    new_word[8*(off+k) +: 8] = wdata[8*k +: 8];
                lat = (nbytes == 4) ? 2 : 3;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rdata, e_word;
        int          e_lat, lat, we0;
        model(we, size, uns, addr, wdata, e_err, e_rdata, e_word, e_lat);
        we0 = we_cnt;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
        chk("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_addr_i = $urandom; req_wdata_i = $urandom; req_we_i = 1'($urandom);
        lat = 1;
        while (!rsp_valid_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("rdata", rsp_rdata_o, e_rdata);
        chk("err", {31'b0, rsp_err_o}, {31'b0, e_err});
        chk("we_pulses", we_cnt - we0, (we && !e_err) ? 1 : 0);
        if (we && !e_err) begin
            chk("waddr", wa, {addr[31:2], 2'b00});
            chk("wdata", wd, e_word);
            ref_mem[addr[7:2]] = e_word;
        end
        got = rsp_rdata_o;
        $display("TXN we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, size, uns, addr, wdata, rsp_rdata_o, rsp_err_o, lat);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("hold_rdata", rsp_rdata_o, e_rdata);
            chk("hold_ready", {31'b0, req_ready_o}, 32'd0);
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        chk("rsp_released", {31'b0, rsp_valid_o}, 32'd0);
        chk("ready_back", {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        logic        seen;
        int          we0;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b0;

        for (int i = 0; i < SPAN; i++) bd_write(i, $urandom);
        #1;
        chk("rst_req_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, g);
        chk("tp_sw_wdata", wd, 32'hDEADBEEF);
        chk("tp_sw_waddr", wa, 32'h10);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("tp_lw", g, 32'hDEADBEEF);

        bd_write(8, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 0, g);
        chk("tp_sb_merge", wd, 32'h11AA3344);

        bd_write(12, 32'h80FF7F01);
        do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 0, g);
        chk("tp_lb", g, 32'hFFFFFFFF);
        do_req(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 0, g);
        chk("tp_lbu", g, 32'h000000FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 0, g);
        chk("tp_lh", g, 32'hFFFF80FF);
        do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 0, g);
        chk("tp_lhu", g, 32'h00007F01);

        do_req(1'b1, 2'd1, 1'b0, 32'h41, 32'h1234, 0, g);
        do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 0, g);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0, g);
        do_req(1'b0, 2'd2, 1'b0, 32'(4 * MEM_WORDS), 32'h0, 0, g);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, g);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, g);

        // Reset during the write cycle of a half store
        we0 = we_cnt;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd1; req_unsigned_i = 1'b0;
        req_addr_i = 32'h52; req_wdata_i = 32'h0000C0DE;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_we_o) break;
        end
        chk("rst_reached_wr", {31'b0, mem_we_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_we_async", {31'b0, mem_we_o}, 32'd0);
        chk("rst_mid_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_mid_ready", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", {31'b0, req_ready_o}, 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid_o;
        end
        chk("rst_no_rsp", {31'b0, seen}, 32'd0);
        chk("rst_ram_kept", ram[20], ref_mem[20]);
        chk("rst_no_write", we_cnt - we0, 0);
        $display("TXN reset during half store at 0x52 -> no response, ram=%h", ram[20]);

        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0)
                a = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 4 * SPAN - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, g);
        end

        for (int i = 0; i < SPAN; i++) chk("final_ram", ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Load/store initiator that drives the word-addressed data RAM port (write enable, address, write data; combinational read data back).
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Performs lane extraction and sign or zero extension for loads.
- Performs read-modify-write for sub-word stores, because the RAM only writes whole words.
- Returns one response per request over a valid/ready handshake.
- Sits between the execute/memory stage and the RAM.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the target RAM; word index >= MEM_WORDS is an access error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data; the value is taken from the low bits.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_rdata_o  output  32  load result; 0 for stores and for errors.
- rsp_err_o  output  1  misaligned, illegal size or out-of-range access.
- mem_we_o  output  1  RAM write enable.
- mem_addr_o  output  32  RAM byte address; bits [1:0] always 0.
- mem_wdata_o  output  32  RAM write data.
- mem_rdata_i  input  32  RAM read data; combinational with mem_addr_o.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - req_ready_o = 0 while rst is low.
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0.
  - mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - Any in-flight request is discarded with no response.
  - mem_we_o falls immediately, so no partial write completes.
- States: IDLE, RD, WR, RESP. req_ready_o = (state == IDLE) and rst high.
- Accept: valid and ready at a rising edge. All request fields are latched at that edge. mem_addr_o = {addr[31:2], 2'b00}, registered.
- Error check at accept:
  - An error is any of:
    - size 11;
    - half with addr[0] = 1;
    - word with addr[1:0] != 0;
    - addr[31:2] >= MEM_WORDS.
  - On error: next state RESP with err = 1 and rdata = 0. No RAM cycle is issued; mem_we_o stays 0.
- Transitions after accept:
  - Load: IDLE -> RD -> RESP.
  - Word store: IDLE -> WR -> RESP.
  - Byte or half store: IDLE -> RD -> WR -> RESP.
- RD (one cycle): mem_we_o = 0.
  - At the closing edge, mem_rdata_i is captured.
  - Load: lane = word >> (8 * addr[1:0]), little-endian. Byte uses bits [7:0], half uses bits [15:0]. The result is extended per req_unsigned_i into rsp_rdata_o.
  - Store: the captured word is merged with the new data; only the addressed byte or half lanes are replaced.
- WR (one cycle): mem_we_o = 1 and mem_wdata_o = the merged word (word store: req_wdata_i). mem_we_o is 1 in exactly one cycle per store.
- RESP: rsp_valid_o = 1 and holds with data stable until an edge where rsp_ready_i = 1.
  - That edge moves the state to IDLE; req_ready_o rises in the next cycle.
  - No new request is accepted while in RESP.
- Latency, from accept edge to first rsp_valid_o cycle:
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- mem_addr_o holds its value outside RD/WR. mem_wdata_o is a don't-care when mem_we_o = 0, but is held for determinism.
- Request inputs are ignored when req_ready_o = 0.

Test Plan:
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF -> one cycle with mem_we_o = 1, mem_addr_o = 0x10, mem_wdata_o = 0xDEADBEEF.
  - then load word at 0x10 -> rsp_rdata_o = 0xDEADBEEF, err = 0.
- Byte store read-modify-write:
  - RAM[0x20] = 0x11223344; store byte 0xAA at 0x22 -> RD cycle then WR cycle with mem_wdata_o = 0x11AA3344.
  - Response arrives 3 cycles after accept.
- Sign and zero extension, RAM[0x30] = 0x80FF7F01:
  - lb 0x32 -> 0xFFFFFFFF.
  - lbu 0x32 -> 0x000000FF.
  - lh 0x32 -> 0xFFFF80FF.
  - lhu 0x30 -> 0x00007F01.
- Errors, each -> response after 1 cycle with err = 1, rdata = 0, mem_we_o never 1:
  - half store at 0x41;
  - word load at 0x42;
  - size 11;
  - addr = 4*MEM_WORDS.
- Response backpressure: hold rsp_ready_i = 0 for 5 cycles.
  - rsp_valid_o and rsp_rdata_o stay stable; req_ready_o stays 0.
  - Release -> IDLE in the next cycle; a back-to-back request is then accepted.
- Reset mid-operation: assert rst low during the WR cycle of a half store.
  - mem_we_o drops asynchronously.
  - After release: state IDLE, req_ready_o = 1, no response is emitted, RAM word unchanged.
